ram_arbiter: RTL and testbench

Round-robin burst arbiter sharing one SimpleRAM-style port (`cen`/`wen`/`addr`/`din`/`dout`, one-cycle registered read) between `NREQ` requesters, e.g. NNA weight loader, activation fetcher and result writer. Each requester issues one burst command (read or write, 1..256 words). The block serialises bursts, generates word-stepped addresses, streams write data in, and routes read data back to the owner.

---
 rtl/ram_arbiter_if.sv | 49 ++++
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signal bundle of the round-robin RAM arbiter.
//
// Requester side (one slice/bit per requester i):
//   req_valid/req_ready      burst command handshake
//   req_we                   1 = write burst, 0 = read burst
//   req_addr[32i+:32]        start byte address
//   req_len[LEN_W*i+:LEN_W]  burst words minus one
//   wr_data/wr_valid/wr_ready  write word stream, owner only
//   rd_data/rd_valid         read return (shared data, per-requester valid)
//   done                     one-cycle burst completion pulse
// RAM side:
//   ram_cen/ram_wen/ram_addr/ram_din  single-port RAM command
//   ram_dout                 read data, one cycle after a read command
//
// slave  : arbiter view
// master : requesters + RAM view
interface ram_arbiter_if #(
   parameter int NREQ  = 2,
   parameter int LEN_W = 8
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       req_we;
   logic [NREQ*32-1:0]    req_addr;
   logic [NREQ*LEN_W-1:0] req_len;
   logic [NREQ*32-1:0]    wr_data;
   logic [NREQ-1:0]       wr_valid;
   logic [NREQ-1:0]       wr_ready;
   logic [31:0]           rd_data;
   logic [NREQ-1:0]       rd_valid;
   logic [NREQ-1:0]       done;
   logic                  ram_cen;
   logic                  ram_wen;
   logic [31:0]           ram_addr;
   logic [31:0]           ram_din;
   logic [31:0]           ram_dout;

   modport slave (
      input  req_valid, req_we, req_addr, req_len, wr_data, wr_valid, ram_dout,
      output req_ready, wr_ready, rd_data, rd_valid, done,
             ram_cen, ram_wen, ram_addr, ram_din
   );

   modport master (
      output req_valid, req_we, req_addr, req_len, wr_data, wr_valid, ram_dout,
      input  req_ready, wr_ready, rd_data, rd_valid, done,
             ram_cen, ram_wen, ram_addr, ram_din
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin burst arbiter sharing one single-port RAM between NREQ
// requesters. Bursts are serialised, addresses step by 4 bytes per word
// (wrapping modulo 2^32), write words stream in from the owner and read
// words are routed back to the owner one cycle after each RAM read.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      ram_arbiter_if.slave: requester handshakes and RAM port
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no burst; round-robin grant of a new command
// S_READ  | one RAM read issued per cycle for the owner
// S_DRAIN | RAM idle, last read word returns, done pulses
// S_WRITE | one RAM write per cycle in which the owner's wr_valid is high
module ram_arbiter #(
   parameter int NREQ  = 2,
   parameter int LEN_W = 8
) (
   input logic            i_clk,
   input logic            i_rst_n,
   ram_arbiter_if.slave   bus
);

   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [OW-1:0]    r_owner;
   logic [OW-1:0]    r_rr_ptr;
   logic [31:0]      r_cur_addr;
   logic [LEN_W-1:0] r_beats_left;
   logic             r_rd_pend;

   logic [OW-1:0]    w_winner;
   logic             w_win_vld;
   logic [OW-1:0]    w_rr_nxt;
   logic             w_grant;
   logic             w_rd_issue;
   logic             w_wr_beat;
   logic             w_last;

   // Winner: first valid requester scanning upward from rr_ptr, modulo NREQ.
   always_comb begin
      int            idx;
      logic [OW-1:0] idx_w;
      w_winner  = '0;
      w_win_vld = 1'b0;
      idx       = 0;
      idx_w     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         idx_w = OW'(idx);
         if (!w_win_vld && bus.req_valid[idx_w]) begin
            w_win_vld = 1'b1;
            w_winner  = idx_w;
         end
      end
   end

   assign w_rr_nxt   = (int'(w_winner) == NREQ - 1) ? '0 : w_winner + OW'(1);
   // Reset gates the grant so every output is quiet while rst_n is low.
   assign w_grant    = i_rst_n && (r_state == S_IDLE) && w_win_vld;
   assign w_rd_issue = (r_state == S_READ);
   assign w_wr_beat  = (r_state == S_WRITE) && bus.wr_valid[r_owner];
   assign w_last     = (r_beats_left == '0);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_state_nxt = bus.req_we[w_winner] ? S_WRITE : S_READ;
            end
         end
         S_READ: begin
            if (w_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_state_nxt = S_IDLE;
         end
         S_WRITE: begin
            if (w_wr_beat && w_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      bus.wr_ready  = '0;
      bus.rd_valid  = '0;
      bus.rd_data   = '0;
      bus.done      = '0;
      bus.ram_cen   = 1'b0;
      bus.ram_wen   = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_din   = '0;

      if (w_grant) begin
         bus.req_ready[w_winner] = 1'b1;
      end
      if (r_state == S_WRITE) begin
         bus.wr_ready[r_owner] = 1'b1;
      end
      if (w_rd_issue) begin
         bus.ram_cen  = 1'b1;
         bus.ram_addr = r_cur_addr;
      end
      if (w_wr_beat) begin
         bus.ram_cen  = 1'b1;
         bus.ram_wen  = 1'b1;
         bus.ram_addr = r_cur_addr;
         bus.ram_din  = bus.wr_data[32*r_owner +: 32];
      end
      // Owner only changes on a grant, which cannot happen while a read
      // word is still in flight, so r_owner is valid for the returning word.
      if (r_rd_pend) begin
         bus.rd_valid[r_owner] = 1'b1;
         bus.rd_data           = bus.ram_dout;
      end
      if ((r_state == S_DRAIN) || (w_wr_beat && w_last)) begin
         bus.done[r_owner] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_owner      <= '0;
         r_rr_ptr     <= '0;
         r_cur_addr   <= '0;
         r_beats_left <= '0;
         r_rd_pend    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_pend <= w_rd_issue;
         if (w_grant) begin
            r_owner      <= w_winner;
            r_cur_addr   <= bus.req_addr[32*w_winner +: 32];
            r_beats_left <= bus.req_len[LEN_W*w_winner +: LEN_W];
            r_rr_ptr     <= w_rr_nxt;
         end else if (w_rd_issue || w_wr_beat) begin
            r_cur_addr <= r_cur_addr + 32'd4;
            if (!w_last) begin
               r_beats_left <= r_beats_left - LEN_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] din;
   } ram_op_t;

   typedef struct {
      int          id;
      logic [31:0] data;
   } rd_exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ram_arbiter_if #(.NREQ(2), .LEN_W(8)) bus ();

   ram_arbiter #(.NREQ(2), .LEN_W(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   logic [31:0] mem  [0:255];
   logic [31:0] gold [0:255];

   ram_op_t exp_ram   [$];
   rd_exp_t exp_rd    [$];
   int      exp_grant [$];
   int      exp_done  [$];

   int n_chk  = 0;
   int n_fail = 0;
   int rdv_cnt0  = 0;
   int done_cnt0 = 0;

   // RAM model: one-cycle registered read
   always @(posedge clk) begin
      if (bus.ram_cen) begin
         if (bus.ram_wen) mem[bus.ram_addr[9:2]] <= bus.ram_din;
         else             bus.ram_dout <= mem[bus.ram_addr[9:2]];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares every DUT output event against the scoreboard queues.
   always @(negedge clk) begin
      ram_op_t op;
      rd_exp_t rx;
      int      g;
      if (rst_n) begin
         if (bus.req_ready != 2'b00) begin
            chk("req_ready_onehot", $countones(bus.req_ready), 1);
            if (exp_grant.size() == 0) chk("grant_unexpected", {30'd0, bus.req_ready}, 0);
            else begin
               g = exp_grant.pop_front();
               chk("grant_id", {30'd0, bus.req_ready}, 32'd1 << g);
            end
         end
         if (bus.ram_cen) begin
            if (exp_ram.size() == 0) chk("ram_op_unexpected", bus.ram_addr, 32'hx);
            else begin
               op = exp_ram.pop_front();
               chk("ram_wen", {31'd0, bus.ram_wen}, {31'd0, op.we});
               chk("ram_addr", bus.ram_addr, op.addr);
               chk("ram_din", bus.ram_din, op.din);
            end
         end else begin
            chk("ram_idle_quiet", {31'd0, bus.ram_wen} | bus.ram_addr | bus.ram_din, 0);
         end
         if (bus.rd_valid != 2'b00) begin
            if (bus.rd_valid[0]) rdv_cnt0++;
            if (exp_rd.size() == 0) chk("rd_unexpected", {30'd0, bus.rd_valid}, 0);
            else begin
               rx = exp_rd.pop_front();
               chk("rd_valid_id", {30'd0, bus.rd_valid}, 32'd1 << rx.id);
               chk("rd_data", bus.rd_data, rx.data);
            end
         end else begin
            chk("rd_data_idle", bus.rd_data, 0);
         end
         if (bus.done != 2'b00) begin
            if (bus.done[0]) done_cnt0++;
            if (exp_done.size() == 0) chk("done_unexpected", {30'd0, bus.done}, 0);
            else begin
               g = exp_done.pop_front();
               chk("done_id", {30'd0, bus.done}, 32'd1 << g);
            end
         end
      end
   end

   task automatic exp_read(input int id, input logic [31:0] addr, input int len);
      logic [31:0] a;
      exp_grant.push_back(id);
      for (int k = 0; k <= len; k++) begin
         a = addr + 32'(4 * k);
         exp_ram.push_back('{1'b0, a, 32'h0});
         exp_rd.push_back('{id, gold[a[9:2]]});
      end
      exp_done.push_back(id);
   endtask

   // Returns one ns after the handshake edge (first cycle of the burst).
   task automatic issue(input int id, input logic we, input logic [31:0] addr, input logic [7:0] len);
      bit got;
      int t;
      @(posedge clk); #1;
      bus.req_we[id]          = we;
      bus.req_addr[32*id +: 32] = addr;
      bus.req_len[8*id +: 8]  = len;
      bus.req_valid[id]       = 1'b1;
      got = 0;
      t   = 0;
      while (!got && t < 2000) begin
         @(negedge clk);
         if (bus.req_ready[id]) got = 1;
         t++;
      end
      if (!got) chk("handshake_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      bus.req_valid[id] = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_grant.size() + exp_ram.size() + exp_rd.size() + exp_done.size()) != 0 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      @(negedge clk);
      chk("scoreboard_drained", exp_grant.size() + exp_ram.size() + exp_rd.size() + exp_done.size(), 0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_req_ready"}, {30'd0, bus.req_ready}, 0);
      chk({nm, "_wr_ready"}, {30'd0, bus.wr_ready}, 0);
      chk({nm, "_rd_valid"}, {30'd0, bus.rd_valid}, 0);
      chk({nm, "_done"}, {30'd0, bus.done}, 0);
      chk({nm, "_ram_ctl"}, {30'd0, bus.ram_cen, bus.ram_wen}, 0);
      chk({nm, "_ram_addr"}, bus.ram_addr, 0);
      chk({nm, "_ram_din"}, bus.ram_din, 0);
      chk({nm, "_rd_data"}, bus.rd_data, 0);
   endtask

   initial begin
      #100000;
      chk("watchdog_expired", 32'd0, 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      int cnt;
      int t;
      int rdv_before;
      int done_before;

      for (int k = 0; k < 256; k++) gold[k] = 32'hC0DE0000 ^ (32'(k) * 32'h00010101);
      gold[4] = 32'h11223344;
      for (int k = 0; k < 256; k++) mem[k] = gold[k];

      rst_n        = 1'b0;
      bus.req_valid = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.wr_data   = '0;
      bus.wr_valid  = '0;
      bus.ram_dout  = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("por");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset mid-burst: requester 1 read len=3 at 0x100, reset in C+2
      exp_grant.push_back(1);
      exp_ram.push_back('{1'b0, 32'h100, 32'h0});
      issue(1, 1'b0, 32'h100, 8'd3);
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.req_we   = 2'b00;
      bus.req_len  = '0;
      bus.req_addr = {32'h30, 32'h10};
      bus.req_valid = 2'b11;
      #1;
      chk_all_zero("midreset");
      repeat (2) @(posedge clk);
      chk("midreset_queues", exp_grant.size() + exp_ram.size() + exp_rd.size() + exp_done.size(), 0);

      // Round-robin: both held, len=0 reads, starting from rr_ptr=0
      for (int r = 0; r < 3; r++) begin
         exp_read(0, 32'h10, 0);
         exp_read(1, 32'h30, 0);
      end
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_grant_after_reset", {30'd0, bus.req_ready}, 32'd1);
      cnt = 1;
      t   = 0;
      while (cnt < 6 && t < 100) begin
         @(negedge clk);
         if (bus.req_ready != 2'b00) cnt++;
         t++;
      end
      chk("rr_grant_count", cnt, 6);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      drain();

      // Single read at 0x10
      exp_read(0, 32'h10, 0);
      issue(0, 1'b0, 32'h10, 8'd0);
      @(negedge clk);
      chk("single_rd_c1_no_valid", {30'd0, bus.rd_valid}, 0);
      @(negedge clk);
      chk("single_rd_c2_valid", {30'd0, bus.rd_valid}, 32'd1);
      chk("single_rd_c2_done", {30'd0, bus.done}, 32'd1);
      chk("single_rd_c2_data", bus.rd_data, 32'h11223344);
      @(negedge clk);
      chk("single_rd_c3_quiet", {30'd0, bus.rd_valid}, 0);
      drain();

      // Write A,B,C from requester 1 at 0x20 with one bubble after A
      exp_grant.push_back(1);
      exp_ram.push_back('{1'b1, 32'h20, 32'hDEADBEEF});
      exp_ram.push_back('{1'b1, 32'h24, 32'hCAFEF00D});
      exp_ram.push_back('{1'b1, 32'h28, 32'h12345678});
      exp_done.push_back(1);
      gold[8]  = 32'hDEADBEEF;
      gold[9]  = 32'hCAFEF00D;
      gold[10] = 32'h12345678;
      issue(1, 1'b1, 32'h20, 8'd2);
      bus.wr_valid[1]      = 1'b1;
      bus.wr_data[63:32]   = 32'hDEADBEEF;
      @(negedge clk);
      chk("wr_ready_owner", {30'd0, bus.wr_ready}, 32'd2);
      @(posedge clk); #1;
      bus.wr_valid[1] = 1'b0;
      @(negedge clk);
      chk("write_bubble_cen", {31'd0, bus.ram_cen}, 0);
      chk("write_bubble_wr_ready", {30'd0, bus.wr_ready}, 32'd2);
      @(posedge clk); #1;
      bus.wr_valid[1]    = 1'b1;
      bus.wr_data[63:32] = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus.wr_data[63:32] = 32'h12345678;
      @(negedge clk);
      chk("write_last_done", {30'd0, bus.done}, 32'd2);
      @(posedge clk); #1;
      bus.wr_valid[1] = 1'b0;
      drain();

      // Read back A,B,C
      exp_read(1, 32'h20, 2);
      issue(1, 1'b0, 32'h20, 8'd2);
      drain();

      // Address wrap
      exp_read(0, 32'hFFFFFFFC, 1);
      issue(0, 1'b0, 32'hFFFFFFFC, 8'd1);
      drain();

      // Long burst with requester 1 waiting
      rdv_before  = rdv_cnt0;
      done_before = done_cnt0;
      exp_read(0, 32'h0, 255);
      exp_read(1, 32'h30, 0);
      issue(0, 1'b0, 32'h0, 8'd255);
      issue(1, 1'b0, 32'h30, 8'd0);
      drain();
      chk("long_rd_valid_count", rdv_cnt0 - rdv_before, 256);
      chk("long_done_count", done_cnt0 - done_before, 1);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
